// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one backing-memory port between the icache and the
// dcache. It grants the port to one master at a time and holds the grant while
// that master keeps requesting. It counts reads in flight and routes each read
// response to the current (or draining) owner.
// Optional build macro: MEM_ARB_RR_EN selects round-robin arbitration in IDLE.
// When the macro is undefined, the dcache has fixed priority.
module mem_port_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_ic_addr,
    input  logic        i_ic_ren,
    output logic        o_ic_ready,
    output logic [31:0] o_ic_rdata,
    output logic        o_ic_valid,
    input  logic [31:0] i_dc_addr,
    input  logic        i_dc_ren,
    input  logic        i_dc_wen,
    input  logic [31:0] i_dc_wdata,
    output logic        o_dc_ready,
    output logic [31:0] o_dc_rdata,
    output logic        o_dc_valid,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,
    output logic [1:0]  o_owner,
    output logic        o_err
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN_I = 2'd1;
    localparam logic [1:0] ST_OWN_D = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IC   = 2'b01;
    localparam logic [1:0] OWN_DC   = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;

    logic ic_req, dc_req;
    logic own_i, own_d;
    logic owner_req, is_write, rd_room;
    logic rd_accept, rsp_ok;
    logic prio_dc, grant_dc;

    assign ic_req = i_ic_ren;
    assign dc_req = i_dc_ren | i_dc_wen;

    assign own_i = (state_q == ST_OWN_I);
    assign own_d = (state_q == ST_OWN_D);

    // The owner's request is only meaningful in an OWN state.
    // A dcache ren+wen pair is treated as a write.
    assign owner_req = (own_i & ic_req) | (own_d & dc_req);
    assign is_write  = own_d & i_dc_wen;
    assign rd_room   = (cnt_q < CNT_MAX);

    assign o_mem_ren = owner_req & ~is_write & rd_room;
    assign o_mem_wen = is_write;

    assign o_ic_ready = own_i & ic_req & i_mem_ready & rd_room;
    assign o_dc_ready = own_d & dc_req & i_mem_ready & (i_dc_wen | rd_room);

    assign rd_accept = o_mem_ren & i_mem_ready;

    // A response with nothing outstanding is dropped and flagged as an error.
    assign rsp_ok = i_mem_valid & (cnt_q != '0);

    assign o_ic_valid = rsp_ok & (owner_q == OWN_IC);
    assign o_dc_valid = rsp_ok & (owner_q == OWN_DC);
    assign o_ic_rdata = i_mem_rdata;
    assign o_dc_rdata = i_mem_rdata;

    assign o_owner = owner_q;
    assign o_err   = err_q;

    // Address and write data come from the owner and are zero outside OWN states.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (own_i) begin
            o_mem_addr = i_ic_addr;
        end else if (own_d) begin
            o_mem_addr  = i_dc_addr;
            o_mem_wdata = i_dc_wdata;
        end
    end

`ifdef MEM_ARB_RR_EN
    logic last_dc_q;

    assign prio_dc = ~last_dc_q;

    // Remember who won the last IDLE arbitration; reset value means icache.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_dc_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && (ic_req | dc_req)) begin
            last_dc_q <= grant_dc;
        end
    end
`else
    assign prio_dc = 1'b1;
`endif

    assign grant_dc = dc_req & (~ic_req | prio_dc);

    // Outstanding-read counter: an accept and a response in the same cycle cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (rd_accept && !rsp_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!rd_accept && rsp_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Grant and release sequencing; the owner tag stays set through DRAIN so responses route correctly.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_dc) begin
                    state_d = ST_OWN_D;
                    owner_d = OWN_DC;
                end else if (ic_req) begin
                    state_d = ST_OWN_I;
                    owner_d = OWN_IC;
                end
            end
            ST_OWN_I, ST_OWN_D: begin
                if (!owner_req) begin
                    if ((cnt_q == '0) && !rd_accept) begin
                        state_d = ST_IDLE;
                        owner_d = OWN_NONE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_d == '0) begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // State, owner tag and counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sticky protocol error: set by a response when nothing is outstanding.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else if (i_mem_valid && (cnt_q == '0)) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and randomized
// traffic checked against a queue-based reference model of the arbiter.
module tb_mem_port_arbiter;

    localparam int MAXO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_ic_addr;
    logic        i_ic_ren;
    logic        o_ic_ready;
    logic [31:0] o_ic_rdata;
    logic        o_ic_valid;
    logic [31:0] i_dc_addr;
    logic        i_dc_ren;
    logic        i_dc_wen;
    logic [31:0] i_dc_wdata;
    logic        o_dc_ready;
    logic [31:0] o_dc_rdata;
    logic        o_dc_valid;
    logic [31:0] o_mem_addr;
    logic        o_mem_ren;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ready;
    logic [31:0] i_mem_rdata;
    logic        i_mem_valid;
    logic [1:0]  o_owner;
    logic        o_err;

    mem_port_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ic_addr   (i_ic_addr),
        .i_ic_ren    (i_ic_ren),
        .o_ic_ready  (o_ic_ready),
        .o_ic_rdata  (o_ic_rdata),
        .o_ic_valid  (o_ic_valid),
        .i_dc_addr   (i_dc_addr),
        .i_dc_ren    (i_dc_ren),
        .i_dc_wen    (i_dc_wen),
        .i_dc_wdata  (i_dc_wdata),
        .o_dc_ready  (o_dc_ready),
        .o_dc_rdata  (o_dc_rdata),
        .o_dc_valid  (o_dc_valid),
        .o_mem_addr  (o_mem_addr),
        .o_mem_ren   (o_mem_ren),
        .o_mem_wen   (o_mem_wen),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ready (i_mem_ready),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_valid (i_mem_valid),
        .o_owner     (o_owner),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: owner (0 none, 1 icache, 2 dcache), drain flag,
    // queue of issuer tags for reads in flight, sticky error, last RR winner.
    int m_own;
    bit m_drain;
    int m_q[$];
    bit m_err;
    bit m_last_d;

    // Expectations for the current cycle, shared by check and update.
    bit e_act, e_req, e_wr, e_ren;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%b expected=%b at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own    = 0;
        m_drain  = 1'b0;
        m_q.delete();
        m_err    = 1'b0;
        m_last_d = 1'b0;
    endtask

    task automatic model_check();
        bit room, icv, dcv, icr, dcr;
        logic [31:0] ea, ew;
        room  = (m_q.size() < MAXO);
        e_act = (m_own != 0) && !m_drain;
        e_req = (m_own == 1) ? i_ic_ren : (m_own == 2) ? (i_dc_ren | i_dc_wen) : 1'b0;
        e_wr  = e_act && (m_own == 2) && i_dc_wen;
        e_ren = e_act && e_req && !e_wr && room;
        icr   = e_act && (m_own == 1) && e_req && i_mem_ready && room;
        dcr   = e_act && (m_own == 2) && e_req && i_mem_ready && (e_wr || room);
        ea    = !e_act ? 32'h0 : (m_own == 1) ? i_ic_addr : i_dc_addr;
        ew    = (e_act && m_own == 2) ? i_dc_wdata : 32'h0;
        icv   = i_mem_valid && (m_q.size() > 0) && (m_q[0] == 1);
        dcv   = i_mem_valid && (m_q.size() > 0) && (m_q[0] == 2);
        chk1("mem_ren", o_mem_ren, e_ren);
        chk1("mem_wen", o_mem_wen, e_wr);
        chk1("ic_ready", o_ic_ready, icr);
        chk1("dc_ready", o_dc_ready, dcr);
        chk1("ic_valid", o_ic_valid, icv);
        chk1("dc_valid", o_dc_valid, dcv);
        chk("mem_addr", o_mem_addr, ea);
        chk("mem_wdata", o_mem_wdata, ew);
        chk("ic_rdata", o_ic_rdata, i_mem_rdata);
        chk("dc_rdata", o_dc_rdata, i_mem_rdata);
        chk("owner", {30'h0, o_owner}, $unsigned(m_own));
        chk1("err", o_err, m_err);
    endtask

    task automatic model_update();
        int pre;
        bit ic, dc, prio_d;
        pre = m_q.size();
        if (i_mem_valid) begin
            if (pre > 0) void'(m_q.pop_front());
            else m_err = 1'b1;
        end
        if (e_ren && i_mem_ready) m_q.push_back(m_own);
        if (m_own == 0) begin
            ic = i_ic_ren;
            dc = i_dc_ren | i_dc_wen;
`ifdef MEM_ARB_RR_EN
            prio_d = !m_last_d;
`else
            prio_d = 1'b1;
`endif
            if (dc && (!ic || prio_d)) begin
                m_own = 2;
                m_last_d = 1'b1;
            end else if (ic) begin
                m_own = 1;
                m_last_d = 1'b0;
            end
        end else if (!m_drain) begin
            if (!e_req) begin
                if (pre == 0) m_own = 0;
                else m_drain = 1'b1;
            end
        end else if (m_q.size() == 0) begin
            m_own   = 0;
            m_drain = 1'b0;
        end
    endtask

    // Called at the sample point (negedge): check, update model, advance to posedge+1.
    task automatic finish_cyc();
        model_check();
        model_update();
        @(posedge i_clk);
        #1;
    endtask

    task automatic cyc();
        #4;
        finish_cyc();
    endtask

    task automatic drive(input bit ic, input bit dr, input bit dw, input bit rdy, input bit val);
        i_ic_ren    = ic;
        i_dc_ren    = dr;
        i_dc_wen    = dw;
        i_mem_ready = rdy;
        i_mem_valid = val;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit       ic, dr, dw, rdy, val;
        bit [1:0] own;
        bit       ren, wen, icr, dcr, icv, dcv, err;
    } vec_t;

    vec_t tbl[22];
    int   exp_own[3];
    int   acc;
    int   seen;

    initial begin
        i_ic_addr   = 32'h0000_1000;
        i_dc_addr   = 32'h0000_0100;
        i_dc_wdata  = 32'hDEAD_BEEF;
        i_mem_rdata = 32'h1234_5678;
        model_reset();

        // ic dr dw rdy val | own ren wen icr dcr icv dcv err
        tbl[0]  = '{1,0,0,0,0, 2'd0, 0,0,0,0,0,0,0};
        tbl[1]  = '{1,0,0,1,0, 2'd1, 1,0,1,0,0,0,0};
        tbl[2]  = '{1,0,0,1,0, 2'd1, 1,0,1,0,0,0,0};
        tbl[3]  = '{1,0,0,1,1, 2'd1, 1,0,1,0,1,0,0};
        tbl[4]  = '{0,0,0,0,1, 2'd1, 0,0,0,0,1,0,0};
        tbl[5]  = '{0,0,0,0,1, 2'd1, 0,0,0,0,1,0,0};
        tbl[6]  = '{0,0,0,0,0, 2'd0, 0,0,0,0,0,0,0};
        tbl[7]  = '{0,0,1,1,0, 2'd0, 0,0,0,0,0,0,0};
        tbl[8]  = '{0,0,1,1,0, 2'd2, 0,1,0,1,0,0,0};
        tbl[9]  = '{0,0,0,0,0, 2'd2, 0,0,0,0,0,0,0};
        tbl[10] = '{0,0,0,0,0, 2'd0, 0,0,0,0,0,0,0};
        tbl[11] = '{1,1,0,0,0, 2'd0, 0,0,0,0,0,0,0};
        tbl[12] = '{1,1,0,1,0, 2'd2, 1,0,0,1,0,0,0};
        tbl[13] = '{1,0,0,1,1, 2'd2, 0,0,0,0,0,1,0};
        tbl[14] = '{1,0,0,0,0, 2'd2, 0,0,0,0,0,0,0};
        tbl[15] = '{1,0,0,0,0, 2'd0, 0,0,0,0,0,0,0};
        tbl[16] = '{1,0,0,1,0, 2'd1, 1,0,1,0,0,0,0};
        tbl[17] = '{0,0,0,0,1, 2'd1, 0,0,0,0,1,0,0};
        tbl[18] = '{0,0,0,0,0, 2'd1, 0,0,0,0,0,0,0};
        tbl[19] = '{0,0,0,0,0, 2'd0, 0,0,0,0,0,0,0};
        tbl[20] = '{0,0,0,0,1, 2'd0, 0,0,0,0,0,0,0};
        tbl[21] = '{0,0,0,0,0, 2'd0, 0,0,0,0,0,0,1};

        // Reset values while reset is held.
        i_rst = 1'b1;
        drive(1, 1, 0, 1, 1);
        #2;
        chk("rst_owner", {30'h0, o_owner}, 32'h0);
        chk1("rst_ren", o_mem_ren, 1'b0);
        chk1("rst_wen", o_mem_wen, 1'b0);
        chk1("rst_icv", o_ic_valid, 1'b0);
        chk1("rst_dcv", o_dc_valid, 1'b0);
        chk1("rst_err", o_err, 1'b0);
        do_reset();

        // Vector table: icache burst, dcache write, contention, spurious response.
        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].ic, tbl[i].dr, tbl[i].dw, tbl[i].rdy, tbl[i].val);
            #4;
            chk($sformatf("v%0d_owner", i), {30'h0, o_owner}, {30'h0, tbl[i].own});
            chk1($sformatf("v%0d_ren", i), o_mem_ren, tbl[i].ren);
            chk1($sformatf("v%0d_wen", i), o_mem_wen, tbl[i].wen);
            chk1($sformatf("v%0d_icr", i), o_ic_ready, tbl[i].icr);
            chk1($sformatf("v%0d_dcr", i), o_dc_ready, tbl[i].dcr);
            chk1($sformatf("v%0d_icv", i), o_ic_valid, tbl[i].icv);
            chk1($sformatf("v%0d_dcv", i), o_dc_valid, tbl[i].dcv);
            chk1($sformatf("v%0d_err", i), o_err, tbl[i].err);
            if (tbl[i].wen) begin
                chk($sformatf("v%0d_wdata", i), o_mem_wdata, 32'hDEAD_BEEF);
                chk($sformatf("v%0d_waddr", i), o_mem_addr, 32'h0000_0100);
            end
            finish_cyc();
        end

        // Sticky error is cleared by async reset without a clock edge.
        #2;
        i_rst = 1'b1;
        #1;
        chk1("err_async_clear", o_err, 1'b0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        model_reset();

        // Outstanding limit: 4 accepts, stall, one response frees one slot.
        do_reset();
        drive(1, 0, 0, 1, 0);
        cyc();
        acc = 0;
        for (int i = 0; i < 7; i++) begin
            #4;
            if (o_ic_ready) acc++;
            finish_cyc();
        end
        chk("limit_accepts", acc, 32'd4);
        i_mem_valid = 1'b1;
        cyc();
        i_mem_valid = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            #4;
            if (o_ic_ready) acc++;
            finish_cyc();
        end
        chk("limit_reopen", acc, 32'd1);
        i_ic_ren = 1'b0;
        for (int i = 0; i < 20; i++) begin
            i_mem_valid = (m_q.size() > 0);
            cyc();
        end
        chk("limit_drained", {30'h0, o_owner}, 32'h0);

        // Reset mid-burst with two reads outstanding.
        do_reset();
        drive(1, 0, 0, 1, 0);
        cyc();
        cyc();
        cyc();
        i_mem_ready = 1'b0;
        #2;
        i_rst = 1'b1;
        i_mem_valid = 1'b1;
        #1;
        chk("mid_owner", {30'h0, o_owner}, 32'h0);
        chk1("mid_ren", o_mem_ren, 1'b0);
        chk1("mid_icr", o_ic_ready, 1'b0);
        chk1("mid_icv", o_ic_valid, 1'b0);
        chk1("mid_dcv", o_dc_valid, 1'b0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        model_reset();
        drive(0, 0, 0, 0, 1);
        cyc();
        i_mem_valid = 1'b0;
        #4;
        chk1("mid_cnt_zero_err", o_err, 1'b1);
        finish_cyc();

        // Three contended arbitration rounds from IDLE.
`ifdef MEM_ARB_RR_EN
        exp_own[0] = 2; exp_own[1] = 1; exp_own[2] = 2;
`else
        exp_own[0] = 2; exp_own[1] = 2; exp_own[2] = 2;
`endif
        do_reset();
        for (int r = 0; r < 3; r++) begin
            drive(1, 1, 0, 0, 0);
            cyc();
            #4;
            chk($sformatf("round%0d_owner", r), {30'h0, o_owner}, $unsigned(exp_own[r]));
            finish_cyc();
            drive(0, 0, 0, 0, 0);
            cyc();
            cyc();
        end

        // Icache waiting behind dcache is granted once dcache releases.
        do_reset();
        drive(1, 1, 0, 0, 0);
        cyc();
        drive(1, 0, 0, 0, 0);
        cyc();
        cyc();
        #4;
        chk("ic_after_dc", {30'h0, o_owner}, 32'h1);
        finish_cyc();

        // Randomized traffic checked by the model, in several reset-separated segments.
        seen = 0;
        for (int s = 0; s < 4; s++) begin
            do_reset();
            for (int c = 0; c < 500; c++) begin
                if ($urandom_range(0, 3) == 0) i_ic_ren = ~i_ic_ren;
                if ($urandom_range(0, 3) == 0) i_dc_ren = ~i_dc_ren;
                if ($urandom_range(0, 5) == 0) i_dc_wen = ~i_dc_wen;
                i_mem_ready = ($urandom_range(0, 3) != 0);
                i_mem_valid = (m_q.size() > 0) ? ($urandom_range(0, 2) == 0)
                                               : ($urandom_range(0, 199) == 0);
                i_ic_addr   = $urandom;
                i_dc_addr   = $urandom;
                i_dc_wdata  = $urandom;
                i_mem_rdata = $urandom;
                if (m_q.size() == MAXO) seen++;
                cyc();
            end
        end
        chk1("rand_hit_limit", seen > 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single backing-memory port between the instruction cache and the data cache miss/write interfaces. It grants the port to one master at a time and holds the grant for a burst of back-to-back requests. It tracks outstanding reads and routes each read response to the master that issued it. It sits between the two cache `o_mem_*`/`i_mem_*` interfaces and the external memory.

## Interface
- `MAX_OUTSTANDING`, default 4: maximum reads in flight; counter width is `$clog2(MAX_OUTSTANDING+1)`.
- `i_clk` input 1: global clock.
- `i_rst` input 1: asynchronous, active-high reset.
- `i_ic_addr` input 32: icache request address.
- `i_ic_ren` input 1: icache read request.
- `o_ic_ready` output 1: icache request accepted this cycle.
- `o_ic_rdata` output 32: read data to icache.
- `o_ic_valid` output 1: icache read response valid.
- `i_dc_addr` input 32: dcache request address.
- `i_dc_ren` input 1: dcache read request.
- `i_dc_wen` input 1: dcache write request.
- `i_dc_wdata` input 32: dcache write data.
- `o_dc_ready` output 1: dcache request accepted this cycle.
- `o_dc_rdata` output 32: read data to dcache.
- `o_dc_valid` output 1: dcache read response valid.
- `o_mem_addr` output 32: memory address.
- `o_mem_ren` output 1: memory read request.
- `o_mem_wen` output 1: memory write request.
- `o_mem_wdata` output 32: memory write data.
- `i_mem_ready` input 1: memory accepts a request this cycle.
- `i_mem_rdata` input 32: memory read data.
- `i_mem_valid` input 1: memory read data valid; responses return in order.
- `o_owner` output 2: current owner; 00 none, 01 icache, 10 dcache.
- `o_err` output 1: sticky protocol error.

## Operation
- States:
  - IDLE (reset).
  - OWN_I and OWN_D (port granted).
  - DRAIN (grant released, reads still in flight).
- IDLE:
  - If any request is present, the arbiter registers a winner and moves to OWN_I or OWN_D.
  - No request is forwarded in the arbitration cycle.
- OWN_X:
  - The owner's request is forwarded combinationally to `o_mem_*`.
  - `o_mem_ren/wen` are gated by `cnt < MAX_OUTSTANDING` for reads. Writes are never gated by `cnt`.
  - `o_X_ready = owner_req & i_mem_ready & (is_write | cnt < MAX_OUTSTANDING)`.
  - The non-owner sees ready=0.
- Release from OWN_X happens in the first cycle the owner presents no request:
  - Goes to IDLE if `cnt == 0` and no accept occurs that cycle.
  - Otherwise goes to DRAIN.
- DRAIN:
  - `o_mem_ren/wen = 0`.
  - Goes to IDLE when `cnt` reaches 0.
  - The owner tag is retained for response routing.
- Outstanding counter `cnt`:
  - +1 on an accepted read.
  - −1 on `i_mem_valid`.
  - Unchanged if both happen in the same cycle.
  - Writes do not count.
- Responses:
  - `o_ic_rdata = o_dc_rdata = i_mem_rdata` (passthrough).
  - `o_X_valid = i_mem_valid & owner==X & cnt != 0`.
- Error: `i_mem_valid` while `cnt == 0` is dropped and sets `o_err`, which stays set until reset.
- `o_mem_addr` and `o_mem_wdata`:
  - Muxed from the owner in OWN states.
  - Zero in IDLE and DRAIN.
- Arbitration (default, fixed priority): dcache wins simultaneous requests.
- `i_dc_ren` and `i_dc_wen` both high is treated as a write.

## Timing
- Reset values:
  - state=IDLE, `cnt=0`, `o_owner=00`, `o_err=0`.
  - All `o_mem_*`, ready and valid outputs are 0.
  - Reset asserted mid-burst or mid-drain returns to IDLE immediately, and in-flight responses are discarded.
- Grant latency:
  - Request seen in IDLE at cycle N.
  - Owner registered at N+1, with the first `o_mem_ren` and possible accept at N+1.
- Back-to-back accepts are allowed every cycle while the owner holds its request.
- Request-to-memory and response-to-master paths are combinational, with no added latency.
- Re-arbitration:
  - Minimum gap between bursts of different owners is 1 IDLE cycle.
  - A transition through DRAIN adds the remaining response latency to that gap.

## Configuration
- `MEM_ARB_RR_EN` defined: IDLE arbitration is round-robin. A 1-bit last-owner register, reset to icache, gives priority to the master that did not own the last grant.
- Undefined: fixed dcache priority; no last-owner register is built.

## Test plan
- Icache-only burst:
  - Stimulus: `i_ic_ren` held for 3 accepts, memory latency 2.
  - Required: `o_owner=01` from N+1; 3 `o_ic_valid` pulses; state goes DRAIN then IDLE; `cnt` ends at 0.
- Simultaneous requests from IDLE:
  - Stimulus: both masters request.
  - Without `MEM_ARB_RR_EN`: `o_owner=10` first, icache granted after dcache releases.
  - With `MEM_ARB_RR_EN`: grants alternate D, I, D over three contended rounds.
- Outstanding limit:
  - Stimulus: `MAX_OUTSTANDING=4`, memory withholds `i_mem_valid`.
  - Required: exactly 4 accepts, then `o_ic_ready=0`. One response re-enables exactly one accept.
- Dcache write:
  - Stimulus: dcache write with addr `0x100`, wdata `0xDEADBEEF`, `i_mem_ready=1`.
  - Required: `o_mem_wen=1`, `o_mem_wdata=0xDEADBEEF`, `o_dc_ready=1`, `cnt` unchanged. Release goes straight to IDLE.
- Spurious response:
  - Stimulus: `i_mem_valid` pulsed while idle.
  - Required: no `o_X_valid`, `o_err=1` and stays high; async `i_rst` clears it without waiting for a clock edge.
- Reset mid-burst:
  - Stimulus: assert `i_rst` with `cnt=2`.
  - Required: `o_owner=00`, `cnt=0`, all requests and valids low immediately.
